// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter with terminal flag
module apb_wait_timer #(
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Count low-pready ACCESS cycles, saturating so a long stall never wraps.
    always_ff @(posedge pclk) begin
        if (preset || clr) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal marks the last permitted wait cycle; with no timeout it never fires.
    generate
        if (TIMEOUT > 0) begin : g_term
            assign terminal = (count == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_term
            assign terminal = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB requester with command/response ports
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    apb_state_e state;
    apb_state_e state_n;
    logic       accept;
    logic       xfer_done;
    logic       xfer_abort;
    logic       timer_term;

    // State register; reset always returns to IDLE, dropping any transfer in flight.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= APB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and bus-phase decode; pready in the deciding cycle beats the timeout.
    always_comb begin
        state_n    = state;
        psel       = 1'b0;
        penable    = 1'b0;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            APB_IDLE: begin
                cmd_ready = !preset && (!rsp_valid || rsp_ready);
                if (cmd_valid && !preset && (!rsp_valid || rsp_ready)) begin
                    accept  = 1'b1;
                    state_n = APB_SETUP;
                end
            end
            APB_SETUP: begin
                psel    = 1'b1;
                state_n = APB_ACCESS;
            end
            APB_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    xfer_done = 1'b1;
                    state_n   = APB_IDLE;
                end else if (timer_term) begin
                    xfer_abort = 1'b1;
                    state_n    = APB_IDLE;
                end
            end
            default: begin
                state_n = APB_IDLE;
            end
        endcase
    end

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk     (pclk),
        .preset   (preset),
        .clr      (accept),
        .en       ((state == APB_ACCESS) && !pready),
        .terminal (timer_term)
    );

    // Capture the command into the bus registers and build the response; fields hold while unconsumed.
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end
            if (xfer_done) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (xfer_abort) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester
module tb_apb_requester;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_requester #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h0;
        rsp_ready = 1'b1; pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
        tick(); tick();
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h want 0", paddr, pwdata, rsp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        preset = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF;
        pready = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0;
        checks++;
        if ({psel, penable} !== 2'b10) begin
            errors++; $display("FAIL wr_setup got %b want 10", {psel, penable});
        end
        tick();
        checks++;
        if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_access got %b %h %h want 111 00000010 deadbeef", {psel, penable, pwrite}, paddr, pwdata);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b10000 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp got %b %h want 10000 00000000", {rsp_valid, rsp_err, rsp_timeout, psel, penable}, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || paddr !== 32'h10 || pwrite !== 1'b1) begin
            errors++; $display("FAIL wr_after got %b %h %b want 0 00000010 1", rsp_valid, paddr, pwrite);
        end
    endtask

    task automatic test_read_wait(input logic err_bit, input logic [31:0] data);
        int en_cycles;
        int stable_bad;
        en_cycles = 0; stable_bad = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h5555_5555;
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (penable) en_cycles++;
            if (paddr !== 32'h24 || pwrite !== 1'b0 || psel !== 1'b1) stable_bad++;
            tick();
        end
        pready = 1'b1; prdata = data; pslverr = err_bit;
        #1;
        if (penable) en_cycles++;
        if (paddr !== 32'h24 || pwrite !== 1'b0 || psel !== 1'b1) stable_bad++;
        tick();
        pslverr = 1'b0; prdata = 32'h0;
        checks++;
        if (en_cycles !== 4 || stable_bad !== 0) begin
            errors++; $display("FAIL rd_wait_access got penable=%0d unstable=%0d want 4 0", en_cycles, stable_bad);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel} !== {1'b1, err_bit, 2'b00} || rsp_rdata !== data) begin
            errors++; $display("FAIL rd_wait_rsp got %b %h want %b %h", {rsp_valid, rsp_err, rsp_timeout, psel}, rsp_rdata, {1'b1, err_bit, 2'b00}, data);
        end
        tick();
    endtask

    task automatic test_timeout();
        int acc;
        acc = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
        pready = 1'b0; prdata = 32'hCAFE_F00D;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 10 && psel; i++) begin
            if (penable) acc++;
            tick();
        end
        checks++;
        if (acc !== 4 || psel !== 1'b0) begin
            errors++; $display("FAIL timeout_cycles got %0d psel=%b want 4 0", acc, psel);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_rsp got %b %h want 111 00000000", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        pready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
        pready = 1'b1; prdata = 32'hA5A5_5A5A; rsp_ready = 1'b0;
        tick();
        cmd_write = 1'b1; cmd_addr = 32'h34; cmd_wdata = 32'h0BAD_F00D;
        tick();
        tick();
        prdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A || rsp_err !== 1'b0 || psel !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got cmd_ready=%b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b100 || paddr !== 32'h34) begin
            errors++; $display("FAIL bp_setup got %b %h want 100 00000034", {psel, penable, rsp_valid}, paddr);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL bp_second_rsp got %b %h want 1 00000000", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_in_access();
        int seen;
        seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++; $display("FAIL rst_acc_pre got %b want 11", {psel, penable});
        end
        preset = 1'b1;
        tick();
        checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            errors++; $display("FAIL rst_acc_abort got %b want 0000", {psel, penable, rsp_valid, cmd_ready});
        end
        preset = 1'b0; pready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_acc_ready got %b want 1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid || psel) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_acc_quiet got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait(1'b0, 32'h1234_5678);
        test_read_wait(1'b1, 32'h8765_4321);
        test_timeout();
        test_backpressure();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB requester (initiator) that drives the requester-side signals of the team's APB interface and consumes the completer-side signals.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Returns read data and error status on a valid/ready response port.
- Sits between the firmware-facing command fabric and the APB peripheral bus; one outstanding transfer at a time.

Parameters:
ADDR_W, 32, address width of cmd_addr/paddr
DATA_W, 32, data width of cmd_wdata/pwdata/prdata/rsp_rdata
TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  input  1  bus clock; all logic on rising edge
preset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  output  DATA_W  read data; 0 for writes and aborted transfers
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  transfer aborted by timeout
paddr  output  ADDR_W  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
pready  input  1  completer ready
prdata  input  DATA_W  completer read data
pslverr  input  1  completer error

Behaviour:
- Reset (preset=1 at an edge): state=IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pwdata, rsp_rdata = 0; wait counter = 0.
  - cmd_ready forced 0 while preset high.
- FSM (state type from package):
  - IDLE -> SETUP on command handshake.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE on pready=1 or on timeout.
  - ACCESS -> ACCESS otherwise.
- cmd_ready = (state==IDLE) && !preset && (!rsp_valid || rsp_ready).
  - A response being consumed in the same cycle permits a new accept.
- On handshake: register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata. Next cycle is SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata held stable throughout SETUP and ACCESS.
- Completion (ACCESS, pready=1 sampled at the edge):
  - Next cycle: psel=0, penable=0, rsp_valid=1.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_err = pslverr; rsp_timeout = 0.
- Minimum latency, zero-wait-state completer:
  - Handshake in cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid=1 in cycle 3.
  - Back-to-back throughput: one transfer per 3 cycles.
- Wait states: each ACCESS cycle with pready=0 increments the wait counter (width clog2(TIMEOUT+1), saturating). Counter clears on entry to SETUP.
- Timeout (TIMEOUT>0): abort if in ACCESS with pready=0 and counter==TIMEOUT-1, i.e. TIMEOUT consecutive low-pready ACCESS cycles.
  - Next cycle: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the deciding cycle wins over timeout.
- Response fields hold stable while rsp_valid=1 && rsp_ready=0. rsp_valid clears the cycle after handshake unless a new response is produced.
- The FSM cannot produce a new response while one is pending, because no command is accepted.
- After a transfer, paddr/pwrite/pwdata keep their last values; psel=0.
- pslverr and prdata are ignored outside ACCESS-with-pready.
- Reset mid-transfer (SETUP or ACCESS): the next cycle has psel=penable=0, no response is produced, and the command is lost.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - Localparam defaults APB_ADDR_W=32, APB_DATA_W=32.
- Sub-module apb_wait_timer:
  - Saturating counter with clear, enable and a terminal flag (parameter TIMEOUT; flag tied 0 when TIMEOUT=0).
  - Instantiated once.

Test Plan:
- Write, zero wait: cmd write addr=0x0000_0010 data=0xDEAD_BEEF, pready=1 -> psel=1/penable=0 cycle 1, penable=1 cycle 2 with paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; rsp_valid cycle 3, rsp_rdata=0, rsp_err=0.
- Read, 3 wait states: read addr=0x24, pready low 3 ACCESS cycles then high with prdata=0x1234_5678 -> penable high 4 cycles, paddr stable; rsp_rdata=0x12345678, rsp_err=0.
- Slave error: read with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held -> cmd_ready=0, response fields stable. rsp_ready=1 -> new command accepted the same cycle; next SETUP one cycle later.
- Reset in ACCESS: preset=1 during a wait-stated ACCESS -> psel=penable=0 next cycle, no rsp_valid, cmd_ready=1 the first cycle after preset drops.
